// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide widths and constants
package cpu_pkg;
  localparam int CPU_XLEN = 32;
  localparam int INSTR_STEP = 4;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: level-counted circular queue with synchronous flush
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // storage is left unreset; entries are meaningless while level is zero
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: sequential instruction fetch into a prefetch queue with redirect flush
module instr_prefetch_unit import cpu_pkg::*; #(
  parameter int XLEN = CPU_XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic [XLEN-1:0]         instr_mem_addr_o,
  output logic                    instr_mem_rd_o,
  input  logic                    instr_mem_ready_i,
  input  logic [XLEN-1:0]         instr_mem_data_i,
  input  logic                    redirect_i,
  input  logic [XLEN-1:0]         redirect_addr_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [XLEN-1:0]         instr_o,
  output logic [XLEN-1:0]         instr_addr_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    misalign_o
);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] pc;
  logic [2*XLEN-1:0] head;
  logic push, pop, full;
  // full blocks the request even if a pop frees a slot this cycle
  assign full = level_o == LW'(DEPTH);
  assign instr_mem_rd_o = rst_i & ~full & ~redirect_i;
  assign push = instr_mem_rd_o & instr_mem_ready_i;
  assign instr_valid_o = level_o != '0;
  assign pop = instr_valid_o & instr_ready_i & ~redirect_i;
  assign instr_mem_addr_o = pc;
  assign {instr_addr_o, instr_o} = head;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      pc <= RESET_ADDR;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= redirect_i & |redirect_addr_i[1:0];
      if (redirect_i) pc <= {redirect_addr_i[XLEN-1:2], 2'b00};
      else if (push) pc <= pc + XLEN'(INSTR_STEP);
    end
  prefetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_i),
    .rst_n(rst_i),
    .flush(redirect_i),
    .push(push),
    .pop(pop),
    .din({pc, instr_mem_data_i}),
    .dout(head),
    .level(level_o)
  );
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb_instr_prefetch_unit: directed and randomized checks against a queue-based reference model
module tb_instr_prefetch_unit;
  localparam int DEPTH = 4;
  logic clk = 0, rst_i = 0;
  logic [31:0] mem_addr, mem_data = 0, redirect_addr = 0, instr, iaddr;
  logic mem_rd, mem_ready = 0, redirect = 0, valid, iready = 0, misalign;
  logic [2:0] level;
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [31:0] pc = 0;
  logic mis = 0;

  instr_prefetch_unit dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_mem_addr_o(mem_addr), .instr_mem_rd_o(mem_rd),
    .instr_mem_ready_i(mem_ready), .instr_mem_data_i(mem_data),
    .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .instr_valid_o(valid), .instr_ready_i(iready),
    .instr_o(instr), .instr_addr_o(iaddr),
    .level_o(level), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  // advance one clock edge and update the reference model from the inputs seen at that edge
  task automatic tick();
    bit do_pop, do_push;
    @(posedge clk);
    if (!rst_i) begin
      q.delete(); pc = 0; mis = 0;
    end else if (redirect) begin
      q.delete(); pc = {redirect_addr[31:2], 2'b00}; mis = |redirect_addr[1:0];
    end else begin
      mis = 0;
      do_pop = q.size() > 0 && iready;
      do_push = q.size() < DEPTH && mem_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin q.push_back({pc, mem_data}); pc = pc + 4; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 0; tick(); tick(); #1;
    checks++; if (level !== 0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (valid !== 0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (mem_rd !== 0) begin errors++; $display("FAIL reset_rd got %b want 0", mem_rd); end
    checks++; if (misalign !== 0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    rst_i = 1;
  endtask

  task automatic test_fill();
    mem_ready = 1; iready = 0;
    for (int k = 0; k < 6; k++) begin
      mem_data = $urandom; #1;
      checks++; if (mem_rd !== (k < 4)) begin errors++; $display("FAIL fill_rd cycle %0d got %b want %b", k, mem_rd, k < 4); end
      if (k < 4) begin
        checks++; if (mem_addr !== 32'(4 * k)) begin errors++; $display("FAIL fill_addr cycle %0d got %h want %h", k, mem_addr, 4 * k); end
      end
      tick();
    end
    checks++; if (level !== 4) begin errors++; $display("FAIL fill_level got %0d want 4", level); end
    mem_ready = 0; iready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (iaddr !== 32'(4 * k) || instr !== q[0][31:0]) begin errors++; $display("FAIL drain_head %0d got %h/%h want %h/%h", k, iaddr, instr, 4 * k, q[0][31:0]); end
      tick();
    end
    checks++; if (valid !== 0) begin errors++; $display("FAIL drain_empty got %b want 0", valid); end
  endtask

  task automatic test_stall_stream();
    logic [31:0] next_addr, first;
    int got = 0, pushed = 0;
    first = pc; next_addr = pc; iready = 1;
    for (int k = 0; k < 24; k++) begin
      mem_ready = (k % 2 == 0); mem_data = $urandom; #1;
      if (mem_rd && mem_ready) pushed++;
      if (valid) begin
        checks++; if (iaddr !== next_addr || instr !== q[0][31:0]) begin errors++; $display("FAIL stream_word got %h/%h want %h/%h", iaddr, instr, next_addr, q[0][31:0]); end
        next_addr = next_addr + 4; got++;
      end
      tick();
    end
    mem_ready = 0;
    while (q.size() > 0) begin
      #1;
      checks++; if (valid !== 1 || iaddr !== next_addr) begin errors++; $display("FAIL stream_tail got %b/%h want 1/%h", valid, iaddr, next_addr); end
      next_addr = next_addr + 4; got++; tick();
    end
    checks++; if (got != pushed || next_addr !== first + 32'(4 * pushed)) begin errors++; $display("FAIL stream_count got %0d want %0d", got, pushed); end
  endtask

  task automatic test_redirect();
    iready = 0; mem_ready = 1;
    for (int k = 0; k < 3; k++) begin mem_data = $urandom; tick(); end
    checks++; if (level !== 3) begin errors++; $display("FAIL redir_prelevel got %0d want 3", level); end
    redirect = 1; redirect_addr = 32'h100; iready = 1; #1;
    checks++; if (mem_rd !== 0) begin errors++; $display("FAIL redir_rd got %b want 0", mem_rd); end
    tick(); redirect = 0; iready = 0; #1;
    checks++; if (level !== 0 || valid !== 0) begin errors++; $display("FAIL redir_flush got %0d/%b want 0/0", level, valid); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL redir_pc got %h want 100", mem_addr); end
    checks++; if (misalign !== 0) begin errors++; $display("FAIL redir_misalign got %b want 0", misalign); end
    mem_data = $urandom; tick(); #1;
    checks++; if (valid !== 1 || iaddr !== 32'h100) begin errors++; $display("FAIL redir_head got %b/%h want 1/100", valid, iaddr); end
  endtask

  task automatic test_misalign();
    redirect = 1; redirect_addr = 32'h203; mem_ready = 0; tick(); redirect = 0; #1;
    checks++; if (misalign !== 1) begin errors++; $display("FAIL misalign_pulse got %b want 1", misalign); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL misalign_addr got %h want 200", mem_addr); end
    tick(); #1;
    checks++; if (misalign !== 0) begin errors++; $display("FAIL misalign_clear got %b want 0", misalign); end
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_addr = 32'hFFFF_FFFC; tick(); redirect = 0;
    mem_ready = 1; iready = 0; mem_data = $urandom; #1;
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h want fffffffc", mem_addr); end
    tick(); mem_ready = 0; #1;
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", mem_addr); end
    checks++; if (valid !== 1 || iaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head got %b/%h want 1/fffffffc", valid, iaddr); end
  endtask

  task automatic test_async_reset();
    redirect = 1; redirect_addr = 32'h40; tick(); redirect = 0;
    mem_ready = 1; iready = 0;
    repeat (2) begin mem_data = $urandom; tick(); end
    mem_ready = 0; #1;
    checks++; if (level !== 2 || mem_rd !== 1) begin errors++; $display("FAIL areset_pre got %0d/%b want 2/1", level, mem_rd); end
    #1 rst_i = 0; #1;
    checks++; if (level !== 0 || valid !== 0 || mem_rd !== 0 || misalign !== 0) begin errors++; $display("FAIL areset_now got %0d/%b/%b/%b want 0/0/0/0", level, valid, mem_rd, misalign); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL areset_addr got %h want 0", mem_addr); end
    tick(); tick(); rst_i = 1; #1;
    checks++; if (mem_rd !== 1 || mem_addr !== 32'h0) begin errors++; $display("FAIL areset_first got %b/%h want 1/0", mem_rd, mem_addr); end
    mem_ready = 1; mem_data = $urandom; tick(); mem_ready = 0; #1;
    checks++; if (valid !== 1 || iaddr !== 32'h0) begin errors++; $display("FAIL areset_head got %b/%h want 1/0", valid, iaddr); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      mem_ready = $urandom_range(0, 3) != 0;
      iready = $urandom_range(0, 2) != 0;
      redirect = $urandom_range(0, 15) == 0;
      redirect_addr = $urandom; mem_data = $urandom; #1;
      checks++; if (mem_rd !== (q.size() < DEPTH && !redirect)) begin errors++; $display("FAIL rnd_rd cycle %0d got %b want %b", k, mem_rd, q.size() < DEPTH && !redirect); end
      checks++; if (mem_addr !== pc) begin errors++; $display("FAIL rnd_addr cycle %0d got %h want %h", k, mem_addr, pc); end
      checks++; if (level !== 3'(q.size()) || valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_level cycle %0d got %0d/%b want %0d", k, level, valid, q.size()); end
      checks++; if (misalign !== mis) begin errors++; $display("FAIL rnd_misalign cycle %0d got %b want %b", k, misalign, mis); end
      if (q.size() != 0) begin
        checks++; if ({iaddr, instr} !== q[0]) begin errors++; $display("FAIL rnd_head cycle %0d got %h/%h want %h", k, iaddr, instr, q[0]); end
      end
      tick();
    end
    redirect = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall_stream();
    test_redirect();
    test_misalign();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_unit.md
INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries; legal values are powers of 2, minimum 2.
REQ-003 SHALL have parameter RESET_ADDR, default 0: first fetch address after reset.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port instr_mem_addr_o, output, XLEN: fetch address.
REQ-007 SHALL have port instr_mem_rd_o, output, 1: fetch request.
REQ-008 SHALL have port instr_mem_ready_i, input, 1: memory completes the request this cycle.
REQ-009 SHALL have port instr_mem_data_i, input, XLEN: instruction word; valid when rd_o & ready_i.
REQ-010 SHALL have port redirect_i, input, 1: flush the queue and restart fetch (taken branch/jump).
REQ-011 SHALL have port redirect_addr_i, input, XLEN: restart address.
REQ-012 SHALL have port instr_valid_o, output, 1: queue head is valid.
REQ-013 SHALL have port instr_ready_i, input, 1: decode consumes the head.
REQ-014 SHALL have port instr_o, output, XLEN: instruction at the queue head.
REQ-015 SHALL have port instr_addr_o, output, XLEN: address of the queue head.
REQ-016 SHALL have port level_o, output, clog2(DEPTH)+1: current queue occupancy.
REQ-017 SHALL have port misalign_o, output, 1: one-cycle pulse flagging a misaligned redirect.

Function
REQ-018 SHALL hold a fetch PC; instr_mem_addr_o = PC.
REQ-019 SHALL drive instr_mem_rd_o = (level < DEPTH) & ~redirect_i.
REQ-020 SHALL complete a fetch on any cycle where rd_o & ready_i: push {PC, data_i} into the queue and advance PC by 4, wrapping modulo 2^XLEN.
REQ-021 SHALL hold PC and request while ready_i = 0; the address SHALL NOT change until completion or redirect.
REQ-022 SHALL pop the head on any cycle where instr_valid_o & instr_ready_i.
REQ-023 SHALL keep the level unchanged on a simultaneous push and pop; push to the tail, pop from the head.
REQ-024 SHALL, when level = DEPTH, hold rd_o low even if a pop occurs in the same cycle; the request resumes the next cycle.
REQ-025 SHALL have a latency of 1 cycle from a fetch completion into an empty queue to instr_valid_o = 1; there is no combinational bypass.
REQ-026 SHALL drive instr_valid_o = (level != 0), with instr_o and instr_addr_o taken from the head entry; their value is don't-care when the queue is empty.
REQ-027 SHALL, on redirect_i, on the next edge: set level to 0 and discard all entries; discard any pop in the same cycle; set PC = {redirect_addr_i[XLEN-1:2], 2'b00}.
REQ-028 SHALL, on redirect_i with redirect_addr_i[1:0] != 0, assert misalign_o for exactly the following cycle; otherwise misalign_o = 0.
REQ-029 SHALL give redirect priority over push, pop and memory completion in the same cycle.
REQ-030 SHALL use queue pointers of clog2(DEPTH) bits that wrap naturally; full/empty is determined from the level counter only.

Reset
REQ-031 SHALL, while rst_i = 0, force PC = RESET_ADDR, level_o = 0, instr_valid_o = 0, instr_mem_rd_o = 0, misalign_o = 0, and clear the pointers.
REQ-032 SHALL abandon an in-flight fetch when reset is asserted mid-fetch; the first request after reset release uses RESET_ADDR.
REQ-033 SHALL NOT reset queue storage contents; they are don't-care while level = 0.

Structure
REQ-034 SHALL take the XLEN default and the instruction step constant (4) from the shared package cpu_pkg.
REQ-035 SHALL implement the queue storage, pointers and level in a single sub-module, prefetch_fifo, parametrised by WIDTH (2*XLEN) and DEPTH; the fetch/redirect control stays in the top.

Verification
REQ-036 SHALL cover reset then ready_i = 1 and instr_ready_i = 0 -> addresses 0x0, 0x4, 0x8, 0xC fetched; level_o = 4; rd_o low from the 5th cycle.
REQ-037 SHALL cover ready_i toggling 1,0,1 with instr_ready_i = 1 -> each word is output exactly once, in order, with matching instr_addr_o, and no duplicates.
REQ-038 SHALL cover redirect_i to 0x100 with level 3 and push and pop in the same cycle -> next cycle level_o = 0, PC = 0x100, and the next head instr_addr_o = 0x100.
REQ-039 SHALL cover redirect to 0x203 -> misalign_o high for one cycle and the fetch address is 0x200.
REQ-040 SHALL cover PC = 0xFFFFFFFC with a completed fetch -> the next fetch address is 0x00000000.
REQ-041 SHALL cover rst_i dropping mid-fetch with level 2 -> outputs go to reset values immediately, without waiting for a clock edge, and the first post-reset request is to RESET_ADDR.
